// File: rtl/sprite_pkg.sv
// Shared constants, widths and FSM state type for the sprite blitter.
package sprite_pkg;
  localparam int SPR_W_D = 21;
  localparam int SPR_H_D = 21;
  localparam int FB_W_D  = 640;
  localparam int FB_H_D  = 480;
  localparam logic [11:0] KEY_COLOR_D = 12'h808;

  localparam int ROM_AW  = 9;
  localparam int FB_AW   = 19;
  localparam int CNT_W   = 5;
  localparam int POS_W   = 10;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} blit_state_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Raster row/col walker: latches placement, mirrors columns, and produces the
// ROM address and screen coordinates of the current pixel.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W = SPR_W_D,
  parameter int SPR_H = SPR_H_D
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [POS_W-1:0]   x_pos_i,
  input  logic [POS_W-1:0]   y_pos_i,
  input  logic               flip_h_i,
  output logic [ROM_AW-1:0]  rom_addr_o,
  output logic [COORD_W-1:0] sx_o,
  output logic [COORD_W-1:0] sy_o,
  output logic               last_o
);
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(SPR_W - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(SPR_H - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] row_q, row_d, col_q, col_d, col_m;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             flip_q, flip_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    x_d    = x_q;
    y_d    = y_q;
    flip_d = flip_q;
    if (load_i) begin
      row_d  = '0;
      col_d  = '0;
      x_d    = x_pos_i;
      y_d    = y_pos_i;
      flip_d = flip_h_i;
    end else if (advance_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      row_q  <= '0;
      col_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      flip_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      x_q    <= x_d;
      y_q    <= y_d;
      flip_q <= flip_d;
    end
  end

  // Mirroring only changes which ROM column is read; the screen column is unchanged.
  assign col_m      = flip_q ? (COL_MAX - col_q) : col_q;
  assign rom_addr_o = ROM_AW'(row_q) * ROM_AW'(SPR_W) + ROM_AW'(col_m);
  assign sx_o       = COORD_W'(x_q) + COORD_W'(col_q);
  assign sy_o       = COORD_W'(y_q) + COORD_W'(row_q);
  assign last_o     = (row_q == ROW_MAX) && (col_q == COL_MAX);
endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from ROM into the frame buffer, one pixel per cycle,
// skipping transparent/off-screen pixels and holding writes under backpressure.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int          SPR_W     = SPR_W_D,
  parameter int          SPR_H     = SPR_H_D,
  parameter int          FB_W      = FB_W_D,
  parameter int          FB_H      = FB_H_D,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_D
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [POS_W-1:0]   x_pos,
  input  logic [POS_W-1:0]   y_pos,
  input  logic               flip_h,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_color,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic               busy,
  output logic               done
);
  blit_state_t        state_q, state_d;
  logic               busy_q, done_q;
  logic               load, advance, last, visible;
  logic [COORD_W-1:0] sx, sy;
  logic [FB_AW-1:0]   lin_addr;

  sprite_addr_gen #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_addr (
    .clk_i     (Clk),
    .rst_n_i   (Reset_n),
    .load_i    (load),
    .advance_i (advance),
    .x_pos_i   (x_pos),
    .y_pos_i   (y_pos),
    .flip_h_i  (flip_h),
    .rom_addr_o(rom_addr),
    .sx_o      (sx),
    .sy_o      (sy),
    .last_o    (last)
  );

  assign visible  = (sx < COORD_W'(FB_W)) && (sy < COORD_W'(FB_H));
  assign fb_we    = (state_q == RUN) && visible && (rom_color != KEY_COLOR);
  // Address arithmetic may wrap for clipped pixels; those never reach the port.
  assign lin_addr = FB_AW'(sy) * FB_AW'(FB_W) + FB_AW'(sx);
  assign fb_addr  = fb_we ? lin_addr : '0;
  assign fb_data  = fb_we ? rom_color : '0;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        advance = !fb_we || fb_ready;
        if (advance && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter against a raster-walk model.
module tb_sprite_blitter;
  logic        Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, flip_h = 1'b0, fb_ready = 1'b0;
  logic [9:0]  x_pos = '0, y_pos = '0;
  logic [8:0]  rom_addr;
  logic [11:0] rom_color, fb_data;
  logic [18:0] fb_addr;
  logic        fb_we, busy, done;

  logic [11:0] rom [0:440];
  bit          rdy [0:4095];
  logic [30:0] exp_q[$], got_q[$];
  int          exp_done, last_done;
  int          n_checks = 0, n_fail = 0;

  assign rom_color = (rom_addr <= 9'd440) ? rom[rom_addr] : 12'h000;

  sprite_blitter dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .x_pos(x_pos), .y_pos(y_pos),
    .flip_h(flip_h), .rom_addr(rom_addr), .rom_color(rom_color), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk the sprite in raster order; a written pixel waits for a ready cycle.
  task automatic model(input logic [9:0] x, input logic [9:0] y, input bit flip, input int cut);
    int t;
    exp_q.delete();
    t = 1;
    for (int r = 0; r < 21; r++) begin
      for (int c = 0; c < 21; c++) begin
        int cc, sx, sy;
        logic [11:0] colr;
        cc   = flip ? 20 - c : c;
        colr = rom[r * 21 + cc];
        sx   = int'(x) + c;
        sy   = int'(y) + r;
        if (sx < 640 && sy < 480 && colr != 12'h808) begin
          while (t < 4095 && !rdy[t]) t++;
          if (cut == 0 || t < cut) exp_q.push_back({19'(sy * 640 + sx), colr});
        end
        t++;
      end
    end
    exp_done = t;
  endtask

  task automatic fill_rom(input bit rnd, input logic [11:0] colr);
    for (int i = 0; i < 441; i++)
      rom[i] = !rnd ? colr : (($urandom_range(9) < 3) ? 12'h808 : 12'($urandom));
  endtask

  task automatic run_blit(input string nm, input logic [9:0] x, input logic [9:0] y,
                          input bit flip, input int mode, input int rst_cyc);
    int done_cyc, post_we, nmin;
    bit stall;
    logic [18:0] pa;
    logic [11:0] pd;
    logic [8:0]  pr;
    for (int i = 0; i < 4096; i++)
      rdy[i] = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(i % 2) : ($urandom_range(3) != 0);
    model(x, y, flip, rst_cyc);
    got_q.delete();
    done_cyc = -1; stall = 1'b0; post_we = 0;
    pa = '0; pd = '0; pr = '0;
    @(posedge Clk); #1;
    start = 1'b1; x_pos = x; y_pos = y; flip_h = flip;
    @(posedge Clk); #1;
    start = 1'b0; x_pos = 10'($urandom); y_pos = 10'($urandom); flip_h = ~flip;
    for (int n = 1; n < 4000; n++) begin
      fb_ready = rdy[n];
      start    = (rst_cyc != 0 && n == 5);
      if (rst_cyc != 0 && n == rst_cyc) Reset_n = 1'b0;
      #3;
      if (n == 1) begin
        check({nm, " busy@1"}, 64'(busy), 64'd1);
        check({nm, " rom_addr@1"}, 64'(rom_addr), flip ? 64'd20 : 64'd0);
      end
      if (stall)
        check({nm, " stall hold"}, {fb_we, fb_addr, fb_data, rom_addr}, {1'b1, pa, pd, pr});
      stall = Reset_n && fb_we && !fb_ready;
      pa = fb_addr; pd = fb_data; pr = rom_addr;
      if (Reset_n && fb_we && fb_ready) got_q.push_back({fb_addr, fb_data});
      if (done) begin done_cyc = n; break; end
      if (rst_cyc != 0 && n == rst_cyc) break;
      @(posedge Clk); #1;
    end
    if (rst_cyc != 0) begin
      @(posedge Clk); #1;
      Reset_n = 1'b1; start = 1'b0;
      #3;
      check({nm, " outputs after reset"}, {rom_addr, fb_we, busy, done, fb_addr, fb_data}, 64'd0);
      for (int k = 0; k < 20; k++) begin
        @(posedge Clk); #4;
        if (fb_we || busy) post_we++;
      end
      check({nm, " activity after reset"}, 64'(post_we), 64'd0);
    end else begin
      last_done = done_cyc;
      check({nm, " done cycle"}, 64'(done_cyc), 64'(exp_done));
      @(posedge Clk); #4;
      check({nm, " idle after done"}, {busy, done}, 64'd0);
    end
    check({nm, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      check({nm, " write"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    fill_rom(1'b0, 12'hE51);
    repeat (3) @(posedge Clk);
    #4;
    check("reset state", {rom_addr, fb_we, busy, done, fb_addr, fb_data}, 64'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    run_blit("opaque", 10'd100, 10'd50, 1'b0, 0, 0);
    check("opaque done@442", 64'(last_done), 64'd442);
    if (got_q.size() > 0) begin
      check("opaque first addr", 64'(got_q[0][30:12]), 64'd32100);
      check("opaque last addr", 64'(got_q[got_q.size()-1][30:12]), 64'd44920);
    end

    fill_rom(1'b0, 12'h808); rom[220] = 12'h222;
    run_blit("transparent", 10'd100, 10'd50, 1'b0, 0, 0);
    check("transparent done@442", 64'(last_done), 64'd442);
    check("transparent count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("transparent pixel", 64'(got_q[0]), {19'd38510, 12'h222});

    fill_rom(1'b0, 12'h808); rom[0] = 12'hFDB;
    run_blit("flip", 10'd0, 10'd0, 1'b1, 0, 0);
    check("flip count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("flip pixel", 64'(got_q[0]), {19'd20, 12'hFDB});

    fill_rom(1'b0, 12'hE51);
    run_blit("clip", 10'd630, 10'd470, 1'b0, 0, 0);
    check("clip count", 64'(got_q.size()), 64'd100);
    check("clip done@442", 64'(last_done), 64'd442);

    run_blit("backpressure", 10'd100, 10'd50, 1'b0, 1, 0);
    check("backpressure done@882", 64'(last_done), 64'd882);

    run_blit("reset midop", 10'd200, 10'd100, 1'b0, 0, 200);
    run_blit("after reset", 10'd300, 10'd200, 1'b0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      logic [9:0] rx, ry;
      fill_rom(1'b1, 12'h000);
      rx = ($urandom_range(2) == 0) ? 10'(610 + $urandom_range(60)) : 10'($urandom_range(600));
      ry = ($urandom_range(2) == 0) ? 10'(450 + $urandom_range(60)) : 10'($urandom_range(440));
      run_blit("random", rx, ry, 1'($urandom), 2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
